// File: rtl/patch_reader.sv
// Streams one N x N patch from a synchronous-read patch store in raster order.
// A 2-entry output FIFO with read credit gives 1 pixel/cycle under backpressure.
module patch_reader #(
    parameter int DW = 10,
    parameter int N = 16,
    localparam int LW = $clog2(N),
    localparam int AW = 2 * LW
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_start,
    output logic          o_rd_en,
    output logic [AW-1:0] o_rd_addr,
    input  logic [DW-1:0] i_rd_R,
    input  logic [DW-1:0] i_rd_G,
    input  logic [DW-1:0] i_rd_B,
    output logic [DW-1:0] o_R,
    output logic [DW-1:0] o_G,
    output logic [DW-1:0] o_B,
    output logic [LW-1:0] o_x,
    output logic [LW-1:0] o_y,
    output logic          o_valid,
    input  logic          i_ready,
    output logic          o_last,
    output logic          o_busy,
    output logic          o_done
);

    localparam int EW = 3 * DW + AW;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state, state_nx;

    logic [AW-1:0] addr;
    logic          all_issued;
    logic          infl;
    logic [AW-1:0] infl_addr;
    logic [1:0]    occ;
    logic [EW-1:0] e0, e1;
    logic [EW-1:0] din;
    logic [2:0]    credit;
    logic          valid;
    logic          pop;
    logic          push;
    logic          issue;
    logic          head_last;
    logic          start_acc;

    assign valid     = (occ != 2'd0);
    assign pop       = valid & i_ready;
    assign push      = infl;
    assign head_last = &e0[AW-1:0];
    assign start_acc = (state == IDLE) & i_start;
    assign din       = {i_rd_R, i_rd_G, i_rd_B, infl_addr};

    // Entries already buffered plus the one landing now must leave room.
    assign credit = {1'b0, occ} + {2'b00, infl} - {2'b00, pop};

    always_comb begin
        issue = 1'b0;
        if (state == RUN && !all_issued && credit < 3'd2)
            issue = 1'b1;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (i_start) state_nx = RUN;
            RUN:  if (pop && head_last) state_nx = DONE;
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            addr       <= '0;
            all_issued <= 1'b0;
        end else if (start_acc) begin
            addr       <= '0;
            all_issued <= 1'b0;
        end else if (issue) begin
            if (&addr)
                all_issued <= 1'b1;
            else
                addr <= addr + AW'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            infl      <= 1'b0;
            infl_addr <= '0;
        end else begin
            infl <= issue;
            if (issue)
                infl_addr <= addr;
        end
    end

    // Head lives in e0; e1 only ever holds the entry behind it.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            occ <= 2'd0;
            e0  <= '0;
            e1  <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (occ == 2'd0)
                        e0 <= din;
                    else
                        e1 <= din;
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    e0  <= e1;
                    occ <= occ - 2'd1;
                end
                2'b11: begin
                    if (occ == 2'd1) begin
                        e0 <= din;
                    end else begin
                        e0 <= e1;
                        e1 <= din;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_rd_en   = issue & ~i_rst;
    assign o_rd_addr = i_rst ? '0 : addr;
    assign o_valid   = valid & ~i_rst;
    assign o_last    = valid & head_last & ~i_rst;
    assign o_R       = i_rst ? '0 : e0[EW-1 -: DW];
    assign o_G       = i_rst ? '0 : e0[EW-DW-1 -: DW];
    assign o_B       = i_rst ? '0 : e0[EW-2*DW-1 -: DW];
    assign o_y       = i_rst ? '0 : e0[AW-1:LW];
    assign o_x       = i_rst ? '0 : e0[LW-1:0];
    assign o_busy    = (state != IDLE) & ~i_rst;
    assign o_done    = (state == DONE) & ~i_rst;

endmodule

// File: tb/tb_patch_reader.sv
// Directed bench for patch_reader: scenario table, spot-beat table and
// hand-written reset / start-collision sequences.
module tb_patch_reader;

    localparam int DW = 10;
    localparam int N  = 16;
    localparam int LW = 4;
    localparam int AW = 8;
    localparam int NB = N * N;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_r, rd_g, rd_b;
    logic [DW-1:0] r, g, b;
    logic [LW-1:0] x, y;
    logic          valid;
    logic          ready;
    logic          last;
    logic          busy;
    logic          done;

    int nvec = 0;
    int nerr = 0;
    int reads = 0;

    always #5 clk = ~clk;

    patch_reader #(.DW(DW), .N(N)) dut (
        .i_clk(clk),
        .i_rst(rst),
        .i_start(start),
        .o_rd_en(rd_en),
        .o_rd_addr(rd_addr),
        .i_rd_R(rd_r),
        .i_rd_G(rd_g),
        .i_rd_B(rd_b),
        .o_R(r),
        .o_G(g),
        .o_B(b),
        .o_x(x),
        .o_y(y),
        .o_valid(valid),
        .i_ready(ready),
        .o_last(last),
        .o_busy(busy),
        .o_done(done)
    );

    always @(posedge clk) begin
        if (rd_en) begin
            rd_r  <= DW'(rd_addr);
            rd_g  <= DW'(rd_addr) + DW'(1);
            rd_b  <= DW'(255) - DW'(rd_addr);
            reads <= reads + 1;
        end
    end

    typedef struct {
        int            k;
        logic [DW-1:0] r;
        logic [DW-1:0] g;
        logic [DW-1:0] b;
        logic [LW-1:0] x;
        logic [LW-1:0] y;
        logic          last;
    } spot_t;

    typedef struct {
        int mode;
        int inj_beat;
        bit inj_done;
    } scen_t;

    spot_t spots[6];
    scen_t scen[4];

    logic [DW-1:0] cap_r[NB];
    logic [DW-1:0] cap_g[NB];
    logic [DW-1:0] cap_b[NB];
    logic [LW-1:0] cap_x[NB];
    logic [LW-1:0] cap_y[NB];
    logic          cap_l[NB];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic run_frame(input int mode, input int inj_beat,
                             input bit inj_done);
        int k, c, done_cnt, done_c, base, outst;
        bit stalled, finished;
        logic [DW-1:0] hold_r;
        logic [LW-1:0] hold_x, hold_y;
        k = 0;
        done_cnt = 0;
        done_c = -1;
        stalled = 0;
        finished = 0;
        hold_r = '0;
        hold_x = '0;
        hold_y = '0;
        @(negedge clk);
        start = 1'b1;
        ready = 1'b0;
        base = reads;
        @(negedge clk);
        start = 1'b0;
        for (c = 0; c < 3000 && !finished; c++) begin
            case (mode)
                0: ready = 1'b1;
                1: ready = 1'($urandom_range(0, 1));
                default: ready = (c >= 20);
            endcase
            start = (inj_beat >= 0 && k == inj_beat);
            #1;
            if (stalled) begin
                chk("stall_r", r, hold_r);
                chk("stall_xy", {x, y}, {hold_x, hold_y});
            end
            outst = reads - base + int'(rd_en) - k - int'(valid && ready);
            chk("outstanding_le2", outst > 2, 0);
            if (mode == 2 && c == 19) begin
                chk("stall_reads", reads - base + int'(rd_en), 2);
                chk("stall_valid", valid, 1);
                chk("stall_head", {r, x, y}, 0);
            end
            if (valid && ready) begin
                chk("beat_rgb", {r, g, b},
                    {DW'(k), DW'(k + 1), DW'(255 - k)});
                chk("beat_xyl", {x, y, last},
                    {LW'(k % 16), LW'(k / 16), 1'(k == 255)});
                if (mode == 0)
                    chk("beat_cycle", c, k + 2);
                if (k < NB) begin
                    cap_r[k] = r;
                    cap_g[k] = g;
                    cap_b[k] = b;
                    cap_x[k] = x;
                    cap_y[k] = y;
                    cap_l[k] = last;
                end
                k++;
            end
            stalled = valid && !ready;
            hold_r = r;
            hold_x = x;
            hold_y = y;
            if (done) begin
                done_cnt++;
                if (done_c < 0)
                    done_c = c;
                if (inj_done)
                    start = 1'b1;
            end
            if (done_c >= 0 && c >= done_c + 5)
                finished = 1;
            @(negedge clk);
        end
        start = 1'b0;
        if (!finished) begin
            nvec++;
            nerr++;
            $display("FAIL frame_timeout: got %0d beats want done", k);
        end
        chk("beats", k, NB);
        chk("done_cnt", done_cnt, 1);
        if (mode == 0)
            chk("done_cycle", done_c, 258);
        #1;
        chk("idle_busy", busy, 0);
        for (int i = 0; i < 6; i++) begin
            chk("spot_rgb",
                {cap_r[spots[i].k], cap_g[spots[i].k], cap_b[spots[i].k]},
                {spots[i].r, spots[i].g, spots[i].b});
            chk("spot_xyl",
                {cap_x[spots[i].k], cap_y[spots[i].k], cap_l[spots[i].k]},
                {spots[i].x, spots[i].y, spots[i].last});
        end
    endtask

    initial begin
        int k;
        spots[0] = '{0,   10'd0,   10'd1,   10'd255, 4'd0,  4'd0,  1'b0};
        spots[1] = '{1,   10'd1,   10'd2,   10'd254, 4'd1,  4'd0,  1'b0};
        spots[2] = '{15,  10'd15,  10'd16,  10'd240, 4'd15, 4'd0,  1'b0};
        spots[3] = '{16,  10'd16,  10'd17,  10'd239, 4'd0,  4'd1,  1'b0};
        spots[4] = '{100, 10'd100, 10'd101, 10'd155, 4'd4,  4'd6,  1'b0};
        spots[5] = '{255, 10'd255, 10'd256, 10'd0,   4'd15, 4'd15, 1'b1};
        scen[0] = '{0, -1,  1'b0};
        scen[1] = '{1, -1,  1'b0};
        scen[2] = '{2, -1,  1'b0};
        scen[3] = '{0, 100, 1'b1};

        rst = 1'b1;
        start = 1'b0;
        ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_ctl", {rd_en, valid, last, busy, done}, 0);
        chk("rst_data", {rd_addr, x, y}, 0);
        chk("rst_rgb", {r, g, b}, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("idle_busy0", busy, 0);

        for (int s = 0; s < 4; s++)
            run_frame(scen[s].mode, scen[s].inj_beat, scen[s].inj_done);

        // Reset while beat 50 is at the head.
        @(negedge clk);
        start = 1'b1;
        ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        for (int c = 0; c < 400 && !(valid && k == 50); c++) begin
            #1;
            if (valid)
                k++;
            @(negedge clk);
        end
        chk("rst_mid_reach", k, 50);
        rst = 1'b1;
        #1;
        chk("rst_mid_ctl", {rd_en, valid, last, busy, done}, 0);
        chk("rst_mid_data", {rd_addr, x, y, r, g, b}, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_next_ctl", {rd_en, valid, last, busy, done}, 0);
        chk("rst_next_data", {rd_addr, x, y, r, g, b}, 0);
        @(negedge clk);
        #1;
        chk("rst_drop", {valid, busy}, 0);
        run_frame(0, -1, 1'b0);

        // Reset wins over a simultaneous start.
        @(negedge clk);
        start = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        start = 1'b0;
        rst = 1'b0;
        #1;
        chk("startrst_busy", {busy, valid, rd_en}, 0);
        @(negedge clk);
        #1;
        chk("startrst_busy2", {busy, valid, rd_en}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
